// File: rtl/q12_4_pkg.sv
`default_nettype none
// ============================================================================
// Module  : q12_4_pkg
// Brief   : Shared opcodes, Q12.4 limits, FSM encoding and saturation helper.
// Revision: 1.0
// ============================================================================
package q12_4_pkg;

   localparam int FRAC_BITS = 4;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [15:0] Q_MAX_POS = 16'h7FFF;
   localparam logic [15:0] Q_MAX_NEG = 16'h8000;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_MUL    = 2'd1;
   localparam logic [1:0] S_DIV    = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   typedef struct packed {
      logic        ovf;
      logic [15:0] val;
   } sat_t;

   // Sign/magnitude to clamped two's complement; a zero magnitude never yields -0.
   function automatic sat_t q_saturate(input logic neg, input logic [27:0] mag);
      sat_t s;
      s.ovf = 1'b0;
      s.val = 16'h0000;
      if (mag != 28'd0) begin
         if (!neg) begin
            if (mag > 28'h0007FFF) begin
               s.ovf = 1'b1;
               s.val = Q_MAX_POS;
            end else begin
               s.val = mag[15:0];
            end
         end else begin
            if (mag > 28'h0008000) begin
               s.ovf = 1'b1;
               s.val = Q_MAX_NEG;
            end else begin
               s.val = 16'd0 - mag[15:0];
            end
         end
      end
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/q12_4_iter_core.sv
`default_nettype none
// ============================================================================
// Module  : q12_4_iter_core
// Brief   : Shared shift/accumulate datapath: shift-add multiply, restoring divide.
// Revision: 1.0
// ============================================================================
module q12_4_iter_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_step,
   input  logic        i_mode,
   input  logic [19:0] i_lo_init,
   input  logic [15:0] i_operand,
   output logic [27:0] o_mul_mag,
   output logic [19:0] o_quotient
);
   import q12_4_pkg::*;

   // r_acc: product high half or partial remainder; r_lo: multiplier or dividend/quotient
   logic [15:0] r_acc;
   logic [19:0] r_lo;
   logic [15:0] w_acc_nxt;
   logic [19:0] w_lo_nxt;
   logic [16:0] w_sum;
   logic [16:0] w_shift;
   logic        w_ge;
   logic [15:0] w_diff;

   assign w_sum   = {1'b0, r_acc} + {1'b0, (r_lo[0] ? i_operand : 16'd0)};
   assign w_shift = {r_acc, r_lo[19]};
   assign w_ge    = w_shift >= {1'b0, i_operand};
   assign w_diff  = w_shift[15:0] - i_operand;

   always_comb begin
      w_acc_nxt = r_acc;
      w_lo_nxt  = r_lo;
      if (i_load) begin
         w_acc_nxt = 16'd0;
         w_lo_nxt  = i_lo_init;
      end else if (i_step) begin
         if (i_mode) begin
            w_acc_nxt = w_ge ? w_diff : w_shift[15:0];
            w_lo_nxt  = {r_lo[18:0], w_ge};
         end else begin
            w_acc_nxt = w_sum[16:1];
            w_lo_nxt  = {4'd0, w_sum[0], r_lo[15:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc <= 16'd0;
         r_lo  <= 20'd0;
      end else begin
         r_acc <= w_acc_nxt;
         r_lo  <= w_lo_nxt;
      end
   end

   assign o_mul_mag  = {r_acc, r_lo[15:FRAC_BITS]};
   assign o_quotient = r_lo;

endmodule
`default_nettype wire

// File: rtl/fixed_point_alu_q12_4.sv
`default_nettype none
// ============================================================================
// Module  : fixed_point_alu_q12_4
// Brief   : Sequential signed Q12.4 add/sub/mul/div with start/done handshake.
// Revision: 1.0
// ============================================================================
module fixed_point_alu_q12_4 #(
   parameter int FRAC_BITS = q12_4_pkg::FRAC_BITS,
   parameter int WIDTH     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic             div_by_zero
);
   import q12_4_pkg::*;

   localparam logic [4:0] c_MUL_LAST = 5'd15;
   localparam logic [4:0] c_DIV_LAST = 5'd19;
   localparam logic [4:0] c_FIN_LAST = 5'd1;

   logic [1:0]       r_state, w_next_state;
   logic [4:0]       r_cnt;
   logic [1:0]       r_op;
   logic [WIDTH:0]   r_mag_a, r_mag_b;
   logic             r_sign_a, r_sign_b, r_dbz;
   logic             r_raw_neg;
   logic [27:0]      r_raw_mag;
   logic [WIDTH-1:0] r_result;
   logic             r_done, r_overflow, r_div_by_zero;

   logic             w_accept, w_core_load, w_core_step, w_fin_calc, w_fin_write, w_busy;
   logic [WIDTH:0]   w_a_ext, w_b_ext, w_mag_a, w_mag_b;
   logic [WIDTH:0]   w_sa, w_sb, w_sum, w_sum_mag;
   logic [19:0]      w_lo_init, w_quotient;
   logic [27:0]      w_mul_mag;
   sat_t             w_sat;

   assign w_a_ext = {a[WIDTH-1], a};
   assign w_b_ext = {b[WIDTH-1], b};
   assign w_mag_a = a[WIDTH-1] ? -w_a_ext : w_a_ext;
   assign w_mag_b = b[WIDTH-1] ? -w_b_ext : w_b_ext;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MUL)                     w_next_state = S_MUL;
               else if (op == OP_DIV && b != '0)     w_next_state = S_DIV;
               else                                  w_next_state = S_FINISH;
            end
         end
         S_MUL:    if (r_cnt == c_MUL_LAST) w_next_state = S_FINISH;
         S_DIV:    if (r_cnt == c_DIV_LAST) w_next_state = S_FINISH;
         S_FINISH: if (r_cnt == c_FIN_LAST) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // FINISH spans two cycles: form sign/magnitude, then saturate into result
   always_comb begin
      w_accept    = (r_state == S_IDLE) && start;
      w_core_load = w_accept;
      w_core_step = (r_state == S_MUL) || (r_state == S_DIV);
      w_fin_calc  = (r_state == S_FINISH) && (r_cnt == 5'd0);
      w_fin_write = (r_state == S_FINISH) && (r_cnt == c_FIN_LAST);
      w_busy      = (r_state != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                               r_cnt <= 5'd0;
      else if (r_state == S_IDLE || w_next_state != r_state) r_cnt <= 5'd0;
      else                                                    r_cnt <= r_cnt + 5'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op     <= OP_ADD;
         r_mag_a  <= '0;
         r_mag_b  <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_dbz    <= 1'b0;
      end else if (w_accept) begin
         r_op     <= op;
         r_mag_a  <= w_mag_a;
         r_mag_b  <= w_mag_b;
         r_sign_a <= a[WIDTH-1];
         r_sign_b <= b[WIDTH-1];
         r_dbz    <= (op == OP_DIV) && (b == '0);
      end
   end

   assign w_lo_init = (op == OP_DIV) ? {w_mag_a[WIDTH-1:0], {FRAC_BITS{1'b0}}}
                                     : {4'd0, w_mag_b[WIDTH-1:0]};

   q12_4_iter_core u_iter_core (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_core_load),
      .i_step     (w_core_step),
      .i_mode     (r_op == OP_DIV),
      .i_lo_init  (w_lo_init),
      .i_operand  ((r_op == OP_DIV) ? r_mag_b[WIDTH-1:0] : r_mag_a[WIDTH-1:0]),
      .o_mul_mag  (w_mul_mag),
      .o_quotient (w_quotient)
   );

   assign w_sa      = r_sign_a ? -r_mag_a : r_mag_a;
   assign w_sb      = r_sign_b ? -r_mag_b : r_mag_b;
   assign w_sum     = (r_op == OP_SUB) ? (w_sa - w_sb) : (w_sa + w_sb);
   assign w_sum_mag = w_sum[WIDTH] ? -w_sum : w_sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_raw_neg <= 1'b0;
         r_raw_mag <= 28'd0;
      end else if (w_fin_calc) begin
         case (r_op)
            OP_ADD, OP_SUB: begin
               r_raw_neg <= w_sum[WIDTH];
               r_raw_mag <= {11'd0, w_sum_mag};
            end
            OP_MUL: begin
               r_raw_neg <= r_sign_a ^ r_sign_b;
               r_raw_mag <= w_mul_mag;
            end
            OP_DIV: begin
               r_raw_neg <= r_sign_a ^ r_sign_b;
               r_raw_mag <= {8'd0, w_quotient};
            end
         endcase
      end
   end

   assign w_sat = q_saturate(r_raw_neg, r_raw_mag);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_result      <= '0;
         r_done        <= 1'b0;
         r_overflow    <= 1'b0;
         r_div_by_zero <= 1'b0;
      end else begin
         r_done <= w_fin_write;
         if (w_fin_write) begin
            if (r_dbz) begin
               r_result      <= (r_mag_a == '0) ? '0 : (r_sign_a ? Q_MAX_NEG : Q_MAX_POS);
               r_overflow    <= 1'b0;
               r_div_by_zero <= 1'b1;
            end else begin
               r_result      <= w_sat.val;
               r_overflow    <= w_sat.ovf;
               r_div_by_zero <= 1'b0;
            end
         end
      end
   end

   assign result      = r_result;
   assign busy        = w_busy;
   assign done        = r_done;
   assign overflow    = r_overflow;
   assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire
